cla_subtractor_16bit_pipe: RTL and testbench

//  Pipelined 16-bit carry-lookahead subtractor: diff = a - b - bin, with a borrow-out.

---
 rtl/cla_subtractor_16bit_pipe_if.sv | 35 +++
 rtl/cla_subtractor_16bit_pipe.sv | 132 +++++++++++++
 tb/tb_cla_subtractor_16bit_pipe.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cla_subtractor_16bit_pipe_if.sv
// Operand/result stream bundle for the pipelined CLA subtractor.
// master = producer+consumer side, slave = the subtractor itself.
// ovf is present only when CLA_SUB_OVF_EN is defined.
interface cla_subtractor_16bit_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef CLA_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
`ifdef CLA_SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
`ifdef CLA_SUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/cla_subtractor_16bit_pipe.sv
// Purpose: diff = a - b - bin as a + ~b + ~bin, one 4-bit CLA slice per stage (optional ovf: CLA_SUB_OVF_EN).
// Latency: STAGES-1 edges from accept to out_valid; one beat per cycle.
// Backpressure: global advance = ~out_valid | out_ready; a stalled output freezes every stage.
module cla_subtractor_16bit_pipe #(
  parameter int WIDTH = 16,           // must be a multiple of SLICE, at least two slices
  parameter int SLICE = 4,
  localparam int STAGES = WIDTH / SLICE
) (
  input logic clk,
  input logic rst,
  cla_subtractor_16bit_pipe_if.slave bus
);

  localparam int LAST = STAGES - 1;
  localparam int MSB  = WIDTH - 1;

  // Per-stage state. Borrow (inverted carry) is stored so that reset gives bout=0.
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] brw_q;
  logic [WIDTH-1:0]  diff_q [STAGES];
  // Operands skewed forward; the last stage consumes them directly from stage LAST-1.
  logic [WIDTH-1:0]  a_q [STAGES-1];
  logic [WIDTH-1:0]  b_q [STAGES-1];

  // What each stage would load on an advance.
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_d [STAGES];
  logic [WIDTH-1:0]  nxt_d [STAGES];
  logic [SLICE:0]    sum   [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] nxt_c;
  logic              adv;

`ifdef CLA_SUB_OVF_EN
  logic ovf_q;
  logic ovf_nxt;
`endif

  // 4-bit lookahead: every carry is a flat sum of generate/propagate products,
  // no carry ripples between bit positions inside the slice.
  function automatic logic [SLICE:0] cla_slice(
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y,
    input logic             ci
  );
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    logic             term;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SLICE; i++) begin
      term = ci;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return {c[SLICE], p ^ c[SLICE-1:0]};
  endfunction

  assign adv           = ~vld_q[LAST] | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[LAST];
  assign bus.diff      = diff_q[LAST];
  assign bus.bout      = brw_q[LAST];

  // Resolve slice k of each stage's incoming operands and merge it into the diff word.
  always_comb begin
    src_a[0] = bus.a;
    src_b[0] = bus.b;
    src_c[0] = ~bus.bin;
    src_d[0] = '0;
    src_v[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = ~brw_q[k-1];
      src_d[k] = diff_q[k-1];
      src_v[k] = vld_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      sum[k]   = cla_slice(src_a[k][k*SLICE +: SLICE], ~src_b[k][k*SLICE +: SLICE], src_c[k]);
      nxt_d[k] = src_d[k];
      nxt_d[k][k*SLICE +: SLICE] = sum[k][SLICE-1:0];
      nxt_c[k] = sum[k][SLICE];
    end
  end

`ifdef CLA_SUB_OVF_EN
  // Signed overflow from operand MSBs and the final diff MSB, aligned with the last stage.
  always_comb begin
    ovf_nxt = (src_a[LAST][MSB] ^ src_b[LAST][MSB]) & (nxt_d[LAST][MSB] ^ src_a[LAST][MSB]);
  end
  assign bus.ovf = ovf_q;
`endif

  // Pipeline registers: everything moves together on adv, everything holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      brw_q <= '0;
      for (int k = 0; k < STAGES; k++) diff_q[k] <= '0;
      for (int k = 0; k < STAGES - 1; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
`ifdef CLA_SUB_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (adv) begin
      vld_q <= src_v;
      brw_q <= ~nxt_c;
      for (int k = 0; k < STAGES; k++) diff_q[k] <= nxt_d[k];
      for (int k = 0; k < STAGES - 1; k++) begin
        a_q[k] <= src_a[k];
        b_q[k] <= src_b[k];
      end
`ifdef CLA_SUB_OVF_EN
      ovf_q <= ovf_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_cla_subtractor_16bit_pipe.sv
// Bench for cla_subtractor_16bit_pipe: literal vectors, stall stream, mid-flight reset, random stream.
// Outputs are sampled #1 after the rising edge or on the falling edge, never at the active edge.
module tb_cla_subtractor_16bit_pipe;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  cla_subtractor_16bit_pipe_if #(.WIDTH(16)) bus ();

  cla_subtractor_16bit_pipe #(.WIDTH(16), .SLICE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
  } exp_t;

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    exp_t        e;
    int          d;
    int          s;
    logic [31:0] dv;
    d      = int'(a) - int'(b) - int'(bin);
    dv     = d;
    e.diff = dv[15:0];
    e.bout = (d < 0);
    s      = int'($signed(a)) - int'($signed(b)) - int'(bin);
    e.ovf  = (s > 32767) || (s < -32768);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One beat through an idle pipe with literal expectations; also checks the latency.
  task automatic send_one(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic bin, input logic [15:0] ed, input logic eb, input logic eo);
    int   lat;
    exp_t m;
    m = model(a, b, bin);
    chk({name, "_model"}, {15'd0, m.bout, m.diff}, {15'd0, eb, ed});
`ifdef CLA_SUB_OVF_EN
    chk({name, "_model_ovf"}, {31'd0, m.ovf}, {31'd0, eo});
`endif
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.bin       = bin;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) break;
    end
    chk({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({name, "_latency"}, lat, 32'd3);
    chk({name, "_diff"}, {16'd0, bus.diff}, {16'd0, ed});
    chk({name, "_bout"}, {31'd0, bus.bout}, {31'd0, eb});
`ifdef CLA_SUB_OVF_EN
    chk({name, "_ovf"}, {31'd0, bus.ovf}, {31'd0, eo});
`endif
    @(posedge clk); #1;
  endtask

  // Streams n beats; rnd selects random operands/valid/ready, otherwise a fixed
  // operand pattern with out_ready low on cycles stall_lo..stall_hi.
  task automatic run_stream(input string name, input int n, input bit rnd,
                            input int stall_lo, input int stall_hi);
    exp_t        q[$];
    exp_t        e;
    int          idx = 0;
    int          got = 0;
    int          cyc = 0;
    logic [15:0] ca;
    logic [15:0] cb;
    logic        cbin;
    logic [15:0] prev_diff = '0;
    logic        held = 1'b0;
    ca   = rnd ? 16'($urandom) : 16'h0000;
    cb   = rnd ? 16'($urandom) : 16'h0003;
    cbin = rnd ? 1'($urandom) : 1'b0;
    while ((idx < n || q.size() != 0) && cyc < 20000) begin
      bus.in_valid  = (idx < n) && (!rnd || $urandom_range(0, 3) != 0);
      bus.a         = ca;
      bus.b         = cb;
      bus.bin       = cbin;
      bus.out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= stall_lo && cyc <= stall_hi);
      @(negedge clk);
      chk({name, "_in_ready"}, {31'd0, bus.in_ready}, {31'd0, (!bus.out_valid || bus.out_ready)});
      if (held) chk({name, "_stall_stable"}, {16'd0, bus.diff}, {16'd0, prev_diff});
      held = bus.out_valid && !bus.out_ready;
      prev_diff = bus.diff;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk({name, "_unexpected_beat"}, 32'd1, 32'd0);
        end else begin
          e = q[0];
          chk({name, "_diff"}, {16'd0, bus.diff}, {16'd0, e.diff});
          chk({name, "_bout"}, {31'd0, bus.bout}, {31'd0, e.bout});
`ifdef CLA_SUB_OVF_EN
          chk({name, "_ovf"}, {31'd0, bus.ovf}, {31'd0, e.ovf});
`endif
          if (bus.out_ready) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(ca, cb, cbin));
        idx++;
        if (rnd) begin
          ca   = 16'($urandom);
          cb   = 16'($urandom);
          cbin = 1'($urandom);
        end else begin
          ca   = 16'(idx * 16'h2345);
          cb   = 16'(idx * 16'h1111 + 3);
          cbin = idx[0];
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_beats_out"}, got, n);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_diff", {16'd0, bus.diff}, 32'd0);
    chk("reset_bout", {31'd0, bus.bout}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

    send_one("v_1234_0234", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    send_one("v_0000_0001", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    send_one("v_0005_0005_b", 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    send_one("v_equal", 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0);
    send_one("v_ffff_0000_b", 16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_one("v_8000_0001", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    send_one("v_7fff_ffff", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

    run_stream("stall8", 8, 1'b0, 4, 6);

    // Fill the pipe with out_ready low, then reset with beats in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'(16'h0100 * (i + 1));
      bus.b        = 16'h0011;
      bus.bin      = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("flush_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_diff", {16'd0, bus.diff}, 32'd0);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("flush_no_stale", {31'd0, bus.out_valid}, 32'd0);
    end
    send_one("v_after_flush", 16'h00FF, 16'h0F00, 1'b0, 16'hF1FF, 1'b1, 1'b0);

    run_stream("random", 1000, 1'b1, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
